// File: rtl/coord_log_pkg.sv
// Shared types for the coordinate logger: frame size, FIFO entry type and serializer states.
package coord_log_pkg;

  localparam int BYTES_PER_FRAME = 8;

  typedef logic [63:0] coord_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO holding captured {x, y} pairs; push and pop may share an edge even when full.
module coord_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wrData,
  output logic [WIDTH-1:0]       rdData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coord_logger.sv
// Logs every change of the (xCoord, yCoord) pair and streams each as an 8-byte MSB-first frame.
// Optional macro COORD_LOG_DROPCNT_EN adds the 16-bit saturating DropCount port.
module coord_logger
  import coord_log_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [31:0]            xCoord,
  input  logic [31:0]            yCoord,
  input  logic                   Enable,
  output logic [7:0]             ByteOut,
  output logic                   ByteValid,
  input  logic                   ByteReady,
  output logic                   FrameStart,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
`ifdef COORD_LOG_DROPCNT_EN
  ,
  output logic [15:0]            DropCount
`endif
);

  localparam int IW = $clog2(BYTES_PER_FRAME);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_FRAME - 1);

  // Handshake: a byte transfers on a rising edge where ByteValid && ByteReady;
  // ByteValid never depends on ByteReady, and ByteOut/FrameStart hold while stalled.

  logic [31:0]  lastX, lastY;
  state_e       state, stateNext;
  logic [IW-1:0] idx, idxNext;
  coord_entry_t shifter, shiftNext, head;
  logic         full, empty, push, pop, accept, changeEvt, drop;

  assign changeEvt = Enable && ((xCoord != lastX) || (yCoord != lastY));
  assign push      = changeEvt && (!full || pop);
  assign drop      = changeEvt && !push;

  assign ByteValid  = (state == SEND);
  assign ByteOut    = shifter[63:56];
  assign FrameStart = ByteValid && (idx == '0);
  assign accept     = ByteValid && ByteReady;

  coord_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk    (Clk),
    .rst    (Reset),
    .push   (push),
    .pop    (pop),
    .wrData ({xCoord, yCoord}),
    .rdData (head),
    .full   (full),
    .empty  (empty),
    .count  (Count)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      shifter <= '0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      shifter <= shiftNext;
    end
  end

  // The shifter moves left on every accepted byte, so it is all-zero once a frame drains.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    shiftNext = shifter;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shiftNext = head;
          idxNext   = '0;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            idxNext = '0;
            if (!empty) begin
              pop       = 1'b1;
              shiftNext = head;
            end else begin
              shiftNext = shifter << 8;
              stateNext = IDLE;
            end
          end else begin
            idxNext   = idx + IW'(1);
            shiftNext = shifter << 8;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The last-captured pair follows every event, even one whose push is refused.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lastX    <= '0;
      lastY    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (changeEvt) begin
        lastX <= xCoord;
        lastY <= yCoord;
      end
      if (drop) Overflow <= 1'b1;
    end
  end

`ifdef COORD_LOG_DROPCNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DropCount <= '0;
    end else if (drop && (DropCount != 16'hFFFF)) begin
      DropCount <= DropCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coord_logger.sv
// Scoreboard bench for coord_logger: directed coordinate changes, byte stream checked by a monitor.
module tb_coord_logger;

  localparam int DEPTH = 8;

  logic        Clk;
  logic        Reset;
  logic [31:0] xCoord, yCoord;
  logic        Enable;
  logic [7:0]  ByteOut;
  logic        ByteValid;
  logic        ByteReady;
  logic        FrameStart;
  logic [$clog2(DEPTH):0] Count;
  logic        Overflow;
`ifdef COORD_LOG_DROPCNT_EN
  logic [15:0] DropCount;
`endif

  int tests = 0;
  int fails = 0;

  // {frameStart, byte} expected in delivery order
  logic [8:0] exp_q[$];

  logic       hold_valid = 1'b0;
  logic [8:0] hold_val;

  coord_logger #(.DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .xCoord     (xCoord),
    .yCoord     (yCoord),
    .Enable     (Enable),
    .ByteOut    (ByteOut),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .FrameStart (FrameStart),
    .Count      (Count),
    .Overflow   (Overflow)
`ifdef COORD_LOG_DROPCNT_EN
    ,
    .DropCount  (DropCount)
`endif
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] w;
    w = {x, y};
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), w[63 - 8*i -: 8]});
  endtask

  task automatic set_xy(input logic [31:0] x, input logic [31:0] y);
    xCoord = x;
    yCoord = y;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || ByteValid); i++) cyc(1);
    check("drain_remaining", exp_q.size(), 0);
    check("drain_idle_valid", ByteValid, 1'b0);
  endtask

  // monitor: compares every accepted byte, and checks stability across stalls
  always @(negedge Clk) begin
    if (Reset) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) check("stall_stable", {ByteValid, FrameStart, ByteOut}, {1'b1, hold_val});
      if (ByteValid && ByteReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {FrameStart, ByteOut}, 9'h1FF);
        end else begin
          check("stream_byte", {FrameStart, ByteOut}, exp_q.pop_front());
        end
      end
      hold_valid = ByteValid && !ByteReady;
      hold_val   = {FrameStart, ByteOut};
    end
  end

  initial begin
    Reset = 1'b1;
    Enable = 1'b1;
    ByteReady = 1'b1;
    set_xy(32'h0, 32'h0);
    #1;
    check("rst_valid", ByteValid, 1'b0);
    check("rst_byte", ByteOut, 8'h00);
    check("rst_fs", FrameStart, 1'b0);
    check("rst_count", Count, 0);
    check("rst_ovf", Overflow, 1'b0);
`ifdef COORD_LOG_DROPCNT_EN
    check("rst_dropcnt", DropCount, 16'h0);
`endif
    cyc(2);
    Reset = 1'b0;

    // idle after reset: (0,0) matches the reset pair, nothing logged
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle_valid", ByteValid, 1'b0);
    end
    check("idle_count", Count, 0);
    check("idle_ovf", Overflow, 1'b0);

    // single frame with latency check
    set_xy(32'h0000_0005, 32'h0000_000A);
    push_frame(32'h0000_0005, 32'h0000_000A);
    cyc(1);                                   // sampling edge E
    check("lat_e_valid", ByteValid, 1'b0);
    check("lat_e_count", Count, 1);
    cyc(1);                                   // E+1
    check("lat_e1_valid", ByteValid, 1'b1);
    check("lat_e1_fs", FrameStart, 1'b1);
    check("lat_e1_count", Count, 0);
    cyc(8);
    check("single_done_valid", ByteValid, 1'b0);
    check("single_done_q", exp_q.size(), 0);

    // backpressure
    ByteReady = 1'b0;
    set_xy(32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      ByteReady = i[0];
      cyc(1);
    end
    ByteReady = 1'b1;
    wait_drain(20);

    // enable gating
    Enable = 1'b0;
    set_xy(32'hDEAD_BEEF, 32'h0000_1111);
    cyc(4);
    check("gate_off_valid", ByteValid, 1'b0);
    check("gate_off_count", Count, 0);
    set_xy(32'h1234_5678, 32'h9ABC_DEF0);
    cyc(1);
    Enable = 1'b1;
    cyc(4);
    check("gate_same_valid", ByteValid, 1'b0);
    check("gate_same_count", Count, 0);
    set_xy(32'hCAFE_0001, 32'h0BAD_F00D);
    push_frame(32'hCAFE_0001, 32'h0BAD_F00D);
    wait_drain(20);

    // overflow: 10 changes with the sink stalled
    ByteReady = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_xy(32'h100 + 32'(i), 32'h2000 + 32'(i));
      if (i <= 9) push_frame(32'h100 + 32'(i), 32'h2000 + 32'(i));
      cyc(1);
      if (i == 9) begin
        check("ovf_full_count", Count, 8);
        check("ovf_before", Overflow, 1'b0);
      end
    end
    check("ovf_count", Count, 8);
    check("ovf_flag", Overflow, 1'b1);
`ifdef COORD_LOG_DROPCNT_EN
    check("ovf_dropcnt", DropCount, 16'd1);
`endif
    ByteReady = 1'b1;
    wait_drain(120);
    check("ovf_sticky", Overflow, 1'b1);

    // reset mid-frame
    ByteReady = 1'b0;
    set_xy(32'hA1A2_A3A4, 32'hB1B2_B3B4);
    push_frame(32'hA1A2_A3A4, 32'hB1B2_B3B4);
    cyc(2);
    check("mid_valid", ByteValid, 1'b1);
    ByteReady = 1'b1;
    cyc(3);
    ByteReady = 1'b0;
    check("mid_byte3", ByteOut, 8'hA4);
    #2;
    Reset = 1'b1;
    set_xy(32'h0, 32'h0);
    exp_q.delete();
    #1;
    check("mid_rst_valid", ByteValid, 1'b0);
    check("mid_rst_count", Count, 0);
    check("mid_rst_ovf", Overflow, 1'b0);
    cyc(2);
    Reset = 1'b0;
    ByteReady = 1'b1;
    cyc(2);
    check("post_rst_idle", ByteValid, 1'b0);
    set_xy(32'h0000_00C3, 32'h0000_003C);
    push_frame(32'h0000_00C3, 32'h0000_003C);
    wait_drain(20);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
